// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter with a small byte FIFO (8N1 frames).
// Define UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [15:0]   bit_cnt;
  logic [15:0]   bit_cnt_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_next;
  logic [7:0]    shreg;
  logic          tx_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          overflow;

  logic write;
  logic push;
  logic clr_ovf;
  logic full;
  logic empty;
  logic busy;
  logic bit_end;
  logic pop;
  logic push_ok;
  logic ovf_set;
  logic unused_bits;

  assign unused_bits = ^{wdata[31:8], wenable[3:1], addr[1:0]};

  assign write   = sel & wenable[0];
  assign push    = write & (addr[3:2] == 2'd0);
  assign clr_ovf = write & (addr[3:2] == 2'd1) & wdata[3];
  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign busy    = !empty || (state != IDLE);
  assign bit_end = (bit_cnt == BIT_LAST);
  // A pop frees a slot on the same edge, so a push into a full FIFO then survives.
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      overflow <= ovf_set | (overflow & ~clr_ovf);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      bit_idx <= bit_idx_next;
      if (pop) shreg <= mem[rptr];
      tx      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    bit_cnt_next = ((state == IDLE) || bit_end) ? '0 : bit_cnt + 16'd1;
    case (state)
      IDLE:  if (!empty) state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA: begin
        if (bit_end) begin
          bit_idx_next = bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_idx == 3'd7) state_next = PARITY;
`else
          if (bit_idx == 3'd7) state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_next = STOP;
`endif
      STOP:    if (bit_end) state_next = empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // tx is registered from the next state so the start bit appears on the pop edge.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg[bit_idx_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = ^shreg;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        2'd1:    rdata = {28'b0, overflow, empty, full, busy};
        2'd2:    rdata = 32'(CLKS_PER_BIT);
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: queued bytes are checked cycle by cycle on tx.
// Honours UART_TX_PARITY_EN for the expected frame shape.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = CPB * NBITS;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wenable;
  logic [31:0] rdata;
  logic        tx;

  int          checks = 0;
  int          failures = 0;
  int          frames_done = 0;
  int          starts = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  bit          rx_enable;
  logic [7:0]  exp_q[$];

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr),
    .wdata(wdata), .wenable(wenable), .rdata(rdata), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; the write is sampled on the following posedge.
  task automatic writeReg(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
    sel = 1'b1; addr = a; wdata = d; wenable = we;
    @(negedge clk);
  endtask

  task automatic busIdle();
    sel = 1'b0; wenable = 4'b0; wdata = '0; addr = '0;
  endtask

  task automatic readReg(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; addr = a; wenable = 4'b0;
    #1 d = rdata;
    sel = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit sent);
    if (sent) exp_q.push_back(b);
    writeReg(4'h0, {24'hABCDEF, b}, 4'b0001);
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      #2 n++;
    end
    checkOutput("frames_done", frames_done, target);
  endtask

  // Receiver: compares every bit-time cycle of each frame against the expected byte.
  initial begin
    logic [7:0]       b;
    logic [NBITS-1:0] bits;
    forever begin
      @(negedge clk);
      if (rx_enable && !rst && tx === 1'b0) begin
        start_cyc = cyc;
        starts++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_frame", 32'd1, 32'd0);
        end else begin
          b = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
          bits = {1'b1, ^b, b, 1'b0};
`else
          bits = {1'b1, b, 1'b0};
`endif
          for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
              if (k != 0 || c != 0) @(negedge clk);
              checkOutput("frame_bit", {31'b0, tx}, {31'b0, bits[k]});
            end
          end
          frames_done++;
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  rb;
    int          n;
    bit          low_seen;

    rst = 1'b1; rx_enable = 1'b1;
    busIdle();
    repeat (2) @(negedge clk);
    checkOutput("reset_tx", {31'b0, tx}, 32'd1);
    readReg(4'h4, d); checkOutput("reset_status", d, 32'd4);
    rst = 1'b0;
    @(negedge clk);

    readReg(4'h8, d); checkOutput("clks_reg", d, 32'd4);
    readReg(4'h0, d); checkOutput("txdata_read", d, 32'd0);
    readReg(4'hC, d); checkOutput("reg_c_read", d, 32'd0);
    sel = 1'b0; addr = 4'h4;
    #1 checkOutput("sel_low_read", rdata, 32'd0);

    writeReg(4'h0, 32'h0000_005A, 4'b0010);
    busIdle();
    repeat (3) @(negedge clk);
    readReg(4'h4, d); checkOutput("strobe_ignored", d, 32'd4);
    checkOutput("strobe_tx_idle", {31'b0, tx}, 32'd1);

    applyStimulus(8'h55, 1'b1);
    busIdle();
    waitFrames(1, FRAME + 20);
    readReg(4'h4, d); checkOutput("busy_last_stop", d, 32'd5);
    @(negedge clk);
    readReg(4'h4, d); checkOutput("idle_after_frame", d, 32'd4);

    applyStimulus(8'h07, 1'b1);
    busIdle();
    waitFrames(2, FRAME + 20);

    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom_range(0, 255));
      applyStimulus(rb, 1'b1);
    end
    busIdle();
    waitFrames(5, 3 * FRAME + 50);
    @(negedge clk);

    for (int i = 0; i < 6; i++) applyStimulus(8'hC0 + 8'(i), i < 5);
    busIdle();
    readReg(4'h4, d); checkOutput("status_overflow_full", d, 32'hB);
    waitFrames(10, 5 * FRAME + 50);
    @(negedge clk);
    readReg(4'h4, d); checkOutput("overflow_sticky", d, 32'hC);
    writeReg(4'h4, 32'h7, 4'b0001);
    busIdle();
    readReg(4'h4, d); checkOutput("overflow_needs_bit3", d, 32'hC);
    writeReg(4'h4, 32'h8, 4'b0001);
    busIdle();
    readReg(4'h4, d); checkOutput("overflow_cleared", d, 32'h4);

    n = starts;
    for (int i = 0; i < 5; i++) applyStimulus(8'h90 + 8'(i), 1'b1);
    busIdle();
    for (int i = 0; i < 2 * FRAME && starts == n; i++) @(negedge clk);
    checkOutput("full_frame_started", {31'b0, starts > n}, 32'd1);
    for (int i = 0; i < 2 * FRAME && cyc < start_cyc + FRAME - 1; i++) @(negedge clk);
    applyStimulus(8'hA5, 1'b1);
    busIdle();
    readReg(4'h4, d); checkOutput("push_on_pop_full", d, 32'h3);
    waitFrames(16, 6 * FRAME + 50);
    @(negedge clk);

    rx_enable = 1'b0;
    writeReg(4'h0, 32'hA3, 4'b0001);
    writeReg(4'h0, 32'h11, 4'b0001);
    writeReg(4'h0, 32'h22, 4'b0001);
    busIdle();
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_frame_started", {31'b0, tx}, 32'd0);
    repeat (CPB * 4) @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("tx_on_reset", {31'b0, tx}, 32'd1);
    readReg(4'h4, d); checkOutput("status_on_reset", d, 32'd4);
    @(negedge clk);
    rst = 1'b0;
    low_seen = 1'b0;
    repeat (FRAME * 3) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    checkOutput("tx_quiet_after_reset", {31'b0, low_seen}, 32'd0);
    readReg(4'h4, d); checkOutput("status_after_reset", d, 32'd4);

    rx_enable = 1'b1;
    applyStimulus(8'h3C, 1'b1);
    busIdle();
    waitFrames(17, FRAME + 20);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries (power of two, 2..64).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sel  input  1  CPU data address decoded to this peripheral.
REQ-006 SHALL have port addr  input  4  byte offset within the peripheral (bits [1:0] ignored).
REQ-007 SHALL have port wdata  input  32  CPU store data.
REQ-008 SHALL have port wenable  input  4  CPU per-byte write strobes.
REQ-009 SHALL have port rdata  output  32  combinational read data, valid in the same cycle as sel/addr.
REQ-010 SHALL have port tx  output  1  registered serial line, idle high.

Function
REQ-011 SHALL treat a write as sel=1 with wenable[0]=1; wenable[3:1] SHALL be ignored.
REQ-012 Offset 0x0 (TXDATA) write SHALL push wdata[7:0] into the FIFO; reads SHALL return 0.
REQ-013 Offset 0x4 (STATUS) read SHALL return {28'b0, overflow, empty, full, busy}; busy = FIFO non-empty or FSM not IDLE.
REQ-014 Offset 0x4 write with wdata[3]=1 SHALL clear overflow; other bits SHALL be read-only.
REQ-015 Offset 0x8 read SHALL return CLKS_PER_BIT; offset 0xC and all reads with sel=0 SHALL return 0.
REQ-016 Push to a full FIFO SHALL be dropped and SHALL set sticky overflow, unless a pop occurs on the same edge, in which case the push SHALL be accepted.
REQ-017 Overflow set and clear on the same edge SHALL leave overflow set.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-019 In IDLE with the FIFO non-empty at edge E, the block SHALL pop the head, enter START, and drive tx=0 from E.
REQ-020 Each of START, each DATA bit, PARITY, and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter that resets at each bit boundary.
REQ-021 DATA SHALL send 8 bits LSB first, using a 3-bit index that wraps 7->0 on exit to the next state.
REQ-022 STOP SHALL drive tx=1; at STOP end the FSM SHALL pop the next byte and go directly to START if the FIFO is non-empty, otherwise to IDLE (back-to-back frames with no idle gap).
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from a count of width log2(FIFO_DEPTH)+1.
REQ-024 A push to an empty FIFO SHALL update empty/busy on the following edge.

Reset
REQ-025 While rst=1, the block SHALL immediately drive tx=1, FSM=IDLE, FIFO count/pointers=0, bit counter=0, overflow=0; status then reads 0b0100.
REQ-026 Reset mid-frame SHALL abort the frame and discard all FIFO contents; no partial frame SHALL resume.
REQ-027 FIFO data storage SHALL NOT require reset.

Configuration
REQ-028 With UART_TX_PARITY_EN defined, the block SHALL insert one PARITY bit (even parity = XOR of the 8 data bits) between DATA and STOP, giving an 11-bit frame.
REQ-029 Without UART_TX_PARITY_EN, the PARITY state and logic SHALL be absent, giving a 10-bit frame (DATA->STOP).

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Write 0x55 to 0x0 at edge E, no macro -> tx low during cycles E..E+3, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles; busy=0 from E+40.
REQ-031 Same stimulus with UART_TX_PARITY_EN, byte 0x07 -> data bits 1,1,1,0,0,0,0,0, then parity 1, then stop; frame = 44 cycles.
REQ-032 Write 6 bytes in consecutive cycles while idle -> the first is popped immediately and 4 are queued; the 6th is dropped, so STATUS reads 0b1011 and exactly 5 frames are sent back-to-back; writing 0x8 to 0x4 then clears overflow.
REQ-033 Assert rst for 1 cycle midway through DATA of frame 0xA3 with 2 bytes queued -> tx=1 immediately, STATUS=0b0100, tx stays high until a new write.
REQ-034 FIFO full with a pop on the STOP-end edge and a simultaneous push -> push accepted, overflow stays 0, count unchanged.
REQ-035 Read 0x8 -> rdata=4; read 0x0 or 0xC, or any read with sel=0 -> rdata=0; write with wenable=4'b0010 to 0x0 -> no push.
